// File: rtl/lcd_char_writer.sv
// rtl/lcd_char_writer.sv - HD44780 16x2 power-up, init and continuous two-line refresh writer
// Optional feature macro: LCD_SKIP_UNCHANGED_EN (idle instead of refreshing while iCHARS is unchanged)
module lcd_char_writer #(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 4,
    parameter int EN_CYC      = 16,
    parameter int EXEC_CYC    = 2500,
    parameter int CLEAR_CYC   = 100000
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic [287:0] iCHARS,
    output logic         oBUSY,
    output logic         oFRAME_DONE,
    inout  wire  [7:0]   LCD_DATA,
    output logic         LCD_RW,
    output logic         LCD_EN,
    output logic         LCD_RS
);
    localparam int MAX_A   = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
    localparam int MAX_B   = (EXEC_CYC > EN_CYC) ? EXEC_CYC : EN_CYC;
    localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PWR_LD = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] SET_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD  = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] EXE_LD = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] CLR_LD = CW'(CLEAR_CYC - 1);

    typedef enum logic [2:0] {S_PWRUP, S_INIT, S_FRAME, S_DONE, S_IDLE} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [5:0]     idx_q, idx_d;
    logic [287:0]   snap_q, snap_d;
    logic           en_q, en_d;
    logic           rs_q, rs_d;
    logic [7:0]     data_q, data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           start;
    logic           latch;
    logic [5:0]     widx;
    logic [8:0]     word;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_PWRUP;
            phase_q <= PH_SETUP;
            cnt_q   <= PWR_LD;
            idx_q   <= '0;
            snap_q  <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        start   = 1'b0;
        latch   = 1'b0;
        widx    = '0;
        word    = '0;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == '0) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                    start   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_INIT, S_FRAME: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    case (phase_q)
                        PH_SETUP: begin
                            phase_d = PH_PULSE;
                            en_d    = 1'b1;
                            cnt_d   = EN_LD;
                        end
                        PH_PULSE: begin
                            phase_d = PH_WAIT;
                            en_d    = 1'b0;
                            // Clear-display (third init command) needs the long execution wait
                            cnt_d   = (state_q == S_INIT && idx_q == 6'd2) ? CLR_LD : EXE_LD;
                        end
                        default: begin
                            if (state_q == S_INIT && idx_q == 6'd3) begin
                                state_d = S_FRAME;
                                idx_d   = '0;
                                busy_d  = 1'b0;
                                latch   = 1'b1;
                                start   = 1'b1;
                            end else if (state_q == S_FRAME && idx_q == 6'd33) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end else begin
                                idx_d = idx_q + 1'b1;
                                start = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
`ifdef LCD_SKIP_UNCHANGED_EN
                if (iCHARS == snap_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FRAME;
                    idx_d   = '0;
                    latch   = 1'b1;
                    start   = 1'b1;
                end
`else
                state_d = S_FRAME;
                idx_d   = '0;
                latch   = 1'b1;
                start   = 1'b1;
`endif
            end
        endcase

        if (latch) snap_d = iCHARS;

        // RS/DATA are loaded once at SETUP entry and held through PULSE and WAIT
        if (start) begin
            phase_d = PH_SETUP;
            en_d    = 1'b0;
            cnt_d   = SET_LD;
            if (state_d == S_INIT) begin
                case (idx_d[1:0])
                    2'd0:    word = 9'h038;
                    2'd1:    word = 9'h00C;
                    2'd2:    word = 9'h001;
                    default: word = 9'h006;
                endcase
            end else if (idx_d == 6'd0) begin
                word = 9'h080;
            end else if (idx_d == 6'd17) begin
                word = 9'h0C0;
            end else begin
                widx = (idx_d <= 6'd16) ? idx_d - 6'd1 : idx_d - 6'd2;
                word = snap_q[int'(widx)*9 +: 9];
            end
            rs_d   = word[8];
            data_d = word[7:0];
        end
    end

    assign oBUSY       = busy_q;
    assign oFRAME_DONE = done_q;
    assign LCD_DATA    = data_q;
    assign LCD_RW      = 1'b0;
    assign LCD_EN      = en_q;
    assign LCD_RS      = rs_q;
endmodule

// File: tb/tb_lcd_char_writer.sv
// tb/tb_lcd_char_writer.sv - self-checking bench for lcd_char_writer (strobe sequence, timing, snapshot, reset)
module tb_lcd_char_writer;
    localparam int P_PWR = 20;
    localparam int P_SET = 1;
    localparam int P_EN  = 2;
    localparam int P_EXE = 3;
    localparam int P_CLR = 10;
    localparam int XFER  = P_SET + P_EN + P_EXE;
    localparam int NF    = 5;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         gap;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [287:0] chars = '0;
    wire  [7:0]   lcd_data;
    logic         busy, fdone, rw, en, rs;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int fd_last = -1;
    int busy_fall = -1;

    lcd_char_writer #(
        .POWERUP_CYC(P_PWR), .SETUP_CYC(P_SET), .EN_CYC(P_EN),
        .EXEC_CYC(P_EXE), .CLEAR_CYC(P_CLR)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iCHARS(chars), .oBUSY(busy),
        .oFRAME_DONE(fdone), .LCD_DATA(lcd_data), .LCD_RW(rw),
        .LCD_EN(en), .LCD_RS(rs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fdone === 1'b1) begin
            fd_count = fd_count + 1;
            fd_last  = cyc;
        end
        if (rst_n !== 1'b1) busy_fall = -1;
        else if (busy === 1'b0 && busy_fall < 0) busy_fall = cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Waits for the next EN rise (sampled on negedges), returns its cycle, bus values and high width.
    task automatic next_strobe(output int rc, output int d, output int r, output int w);
        int n;
        n = 0;
        while (en !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("strobe_timeout", 0, 1);
        rc = cyc;
        d  = int'(lcd_data);
        r  = int'(rs);
        w  = 0;
        while (en === 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
    endtask

    function automatic logic [287:0] rand_chars();
        logic [287:0] v;
        for (int i = 0; i < 32; i++) v[9*i +: 9] = 9'($urandom_range(0, 511));
        return v;
    endfunction

    function automatic logic [287:0] put_line1(input logic [287:0] base, input string s);
        logic [287:0] v;
        v = base;
        for (int i = 0; i < 16; i++) v[9*i +: 9] = {1'b1, s[i]};
        return v;
    endfunction

    initial begin
        vec_t         init_tab[4];
        logic [287:0] exp_q[$];
        logic [287:0] cur;
        logic [8:0]   ew;
        int           c0, rc, d, r, w, prev, last33, fd_base, gap, n, rises, cf;
        logic         en_prev;

        init_tab[0] = '{8'h38, 1'b0, XFER};
        init_tab[1] = '{8'h0C, 1'b0, XFER};
        init_tab[2] = '{8'h01, 1'b0, P_SET + P_EN + P_CLR};
        init_tab[3] = '{8'h06, 1'b0, XFER};

        chars = put_line1(rand_chars(), "  BIENVENIDO A  ");
        exp_q.push_back(chars);

        repeat (3) @(negedge clk);
        check("rst_en", en, 0);
        check("rst_rs", rs, 0);
        check("rst_data", lcd_data, 0);
        check("rst_rw", rw, 0);
        check("rst_busy", busy, 1);
        check("rst_frame_done", fdone, 0);

        rst_n = 1'b1;
        c0 = cyc;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            next_strobe(rc, d, r, w);
            if (i == 0) check("first_rise_delay", rc - c0, P_PWR + P_SET);
            else check("init_interval", rc - prev, init_tab[i-1].gap);
            check("init_data", d, init_tab[i].data);
            check("init_rs", r, init_tab[i].rs);
            check("init_en_width", w, P_EN);
            check("init_busy", busy, 1);
            check("init_rw", rw, 0);
            prev = rc;
        end

        fd_base = fd_count;
        last33 = 0;
        for (int f = 0; f < NF; f++) begin
            cur = exp_q[f];
            for (int k = 0; k < 34; k++) begin
                next_strobe(rc, d, r, w);
                if (k == 0) ew = 9'h080;
                else if (k == 17) ew = 9'h0C0;
                else if (k < 17) ew = cur[9*(k-1) +: 9];
                else ew = cur[9*(k-2) +: 9];
                gap = (k == 0 && f > 0) ? XFER + 1 : XFER;
                check("frame_data", d, ew[7:0]);
                check("frame_rs", r, ew[8]);
                check("frame_en_width", w, P_EN);
                check("frame_interval", rc - prev, gap);
                if (k == 0 && f == 0) begin
                    check("busy_fall_cycle", busy_fall, rc - P_SET);
                    check("frame_busy", busy, 0);
                end
                if (k == 0 && f > 0) begin
                    check("frame_done_count", fd_count, fd_base + f);
                    check("frame_done_cycle", fd_last, last33 + P_EN + P_EXE);
                end
                if (k == 9) begin
                    if (f == 0) chars = put_line1(rand_chars(), "Presione A para ");
                    else chars = rand_chars();
                    exp_q.push_back(chars);
                end
                if (k == 33) last33 = rc;
                prev = rc;
            end
        end

        n = 0;
        while (fd_count < fd_base + NF + 1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("hold_frame_done", fd_count, fd_base + NF + 1);

`ifdef LCD_SKIP_UNCHANGED_EN
        rises = 0;
        en_prev = en;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (en === 1'b1 && en_prev !== 1'b1) rises++;
            en_prev = en;
        end
        check("idle_no_strobes", rises, 0);
        check("idle_no_frame_done", fd_count, fd_base + NF + 1);
        chars[9*5] = ~chars[9*5];
        cf = cyc;
        next_strobe(rc, d, r, w);
        check("restart_latency", rc - cf, P_SET + 1);
        check("restart_data", d, 8'h80);
`else
        rises = 0;
        en_prev = 1'b0;
        cf = fd_last;
        next_strobe(rc, d, r, w);
        check("repeat_latency", rc - cf, P_SET + 1);
        check("repeat_data", d, 8'h80);
`endif

        n = 0;
        while (en !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("pulse_seen", en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_en", en, 0);
        check("async_rst_busy", busy, 1);
        check("async_rst_data", lcd_data, 0);
        check("async_rst_rs", rs, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        next_strobe(rc, d, r, w);
        check("restart_first_rise", rc - c0, P_PWR + P_SET);
        check("restart_first_data", d, 8'h38);
        check("restart_first_rs", r, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
